// File: rtl/prog_loader.sv
// Boot-time program loader: streams a header, the data BRAM image, then the instruction BRAM image.
// Optional trailer checksum stage enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int I_DEPTH    = 256,
  parameter int D_DEPTH    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic                  d_bram_init_done,
  output logic                  pc_stall,
  output logic                  busy,
  output logic                  error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA,
    ST_INSTR,
`ifdef PROG_LOADER_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_RUN,
    ST_ERROR
  } state_t;

  localparam logic [16:0] LP_I_DEPTH = 17'(I_DEPTH);
  localparam logic [16:0] LP_D_DEPTH = 17'(D_DEPTH);

  state_t                  r_state, w_next;
  logic [15:0]             r_n_instr, r_n_data, r_cnt;
  logic [ADDR_WIDTH-1:0]   r_i_w_addr, r_d_w_addr;
  logic [DATA_WIDTH-1:0]   r_i_w_dat, r_d_w_dat;
  logic                    r_i_w_enb, r_d_w_enb;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]   r_sum;
`endif

  logic        w_xfer, w_start, w_busy, w_hdr_bad, w_last_d, w_last_i;
  logic [15:0] w_hdr_ni, w_hdr_nd;
  logic [17:0] w_byte;

  assign w_busy   = (r_state == ST_HEADER) || (r_state == ST_DATA) || (r_state == ST_INSTR)
`ifdef PROG_LOADER_CHECKSUM_EN
                 || (r_state == ST_CSUM)
`endif
                 ;
  assign w_xfer    = s_valid & w_busy;
  assign w_start   = start & ~w_busy;
  assign w_hdr_ni  = s_data[31:16];
  assign w_hdr_nd  = s_data[15:0];
  assign w_hdr_bad = (w_hdr_ni == '0) || ({1'b0, w_hdr_ni} > LP_I_DEPTH) ||
                     ({1'b0, w_hdr_nd} > LP_D_DEPTH);
  assign w_last_d  = (r_cnt == r_n_data - 16'd1);
  assign w_last_i  = (r_cnt == r_n_instr - 16'd1);
  assign w_byte    = {r_cnt, 2'b00};

  assign s_ready          = w_busy;
  assign busy             = w_busy;
  assign pc_stall         = (r_state != ST_RUN);
  assign error            = (r_state == ST_ERROR);
  assign d_bram_init_done = (r_state == ST_INSTR) || (r_state == ST_RUN)
`ifdef PROG_LOADER_CHECKSUM_EN
                         || (r_state == ST_CSUM)
`endif
                         ;
  assign i_w_addr = r_i_w_addr;
  assign i_w_dat  = r_i_w_dat;
  assign i_w_enb  = r_i_w_enb;
  assign d_w_addr = r_d_w_addr;
  assign d_w_dat  = r_d_w_dat;
  assign d_w_enb  = r_d_w_enb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_RUN, ST_ERROR: if (start) w_next = ST_HEADER;
      ST_HEADER: if (w_xfer) begin
        if (w_hdr_bad)           w_next = ST_ERROR;
        else if (w_hdr_nd == '0) w_next = ST_INSTR;
        else                     w_next = ST_DATA;
      end
      ST_DATA:  if (w_xfer && w_last_d) w_next = ST_INSTR;
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_INSTR: if (w_xfer && w_last_i) w_next = ST_CSUM;
      ST_CSUM:  if (w_xfer) w_next = (s_data == r_sum) ? ST_RUN : ST_ERROR;
`else
      ST_INSTR: if (w_xfer && w_last_i) w_next = ST_RUN;
`endif
      default:  w_next = ST_IDLE;
    endcase
  end

  // Write strobes are single-cycle; address/data hold their last value between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n_instr  <= '0;
      r_n_data   <= '0;
      r_cnt      <= '0;
      r_i_w_addr <= '0;
      r_i_w_dat  <= '0;
      r_i_w_enb  <= 1'b0;
      r_d_w_addr <= '0;
      r_d_w_dat  <= '0;
      r_d_w_enb  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      r_i_w_enb <= 1'b0;
      r_d_w_enb <= 1'b0;
      if (w_start) begin
        r_cnt <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        r_sum <= '0;
`endif
      end
      if (w_xfer) begin
        case (r_state)
          ST_HEADER: begin
            r_n_instr <= w_hdr_ni;
            r_n_data  <= w_hdr_nd;
            r_cnt     <= '0;
          end
          ST_DATA: begin
            r_d_w_enb  <= 1'b1;
            r_d_w_addr <= w_byte[ADDR_WIDTH-1:0];
            r_d_w_dat  <= s_data;
            r_cnt      <= w_last_d ? '0 : r_cnt + 16'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum      <= r_sum + s_data;
`endif
          end
          ST_INSTR: begin
            r_i_w_enb  <= 1'b1;
            r_i_w_addr <= w_byte[ADDR_WIDTH-1:0];
            r_i_w_dat  <= s_data;
            r_cnt      <= w_last_i ? '0 : r_cnt + 16'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum      <= r_sum + s_data;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule
